// File: rtl/accum_table_ctrl.sv
// accum_table_ctrl: clear/accumulate/drain sequencer for the per-column accumulator table
// Optional: ACCUM_TABLE_CTRL_CLEAR_ON_DRAIN_EN clears the table after each drain.
module accum_table_ctrl #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_COLS = 16,
    localparam int NUM_TILES = MAX_OUT_COLS / SYS_ARR_COLS,
    localparam int AW = $clog2(MAX_OUT_ROWS * NUM_TILES),
    localparam int RW = $clog2(MAX_OUT_ROWS + 1),
    localparam int TW = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1,
    localparam int WA = SYS_ARR_COLS * AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [TW-1:0]           cmd_tile,
    input  logic [RW-1:0]           cmd_rows,
    input  logic                    acc_valid,
    input  logic                    drain_stall,
    output logic                    acc_clear,
    output logic [SYS_ARR_COLS-1:0] acc_wr_en,
    output logic [WA-1:0]           acc_wr_addr,
    output logic [SYS_ARR_COLS-1:0] acc_rd_en,
    output logic [AW-1:0]           acc_rd_addr,
    output logic                    out_valid,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
);
    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, DRAIN, DONE} state_t;
    state_t state;
    logic [TW-1:0] tile;
    logic [RW-1:0] rows, row;
    logic [AW-1:0] cur_addr;
    logic more, inject, rd_go;
    logic [SYS_ARR_COLS-1:0] wv_next;
    logic [WA-1:0] wa_next;
    assign cur_addr = AW'(tile) * AW'(MAX_OUT_ROWS) + AW'(row);
    assign more = row < rows;
    assign inject = state == ACCUM && acc_valid && more;
    // reads follow drain_stall combinationally so a stalled cycle issues nothing
    assign rd_go = state == DRAIN && more && !drain_stall;
    assign acc_rd_en = {SYS_ARR_COLS{rd_go}};
    assign acc_rd_addr = (state == DRAIN && more) ? cur_addr : '0;
    assign busy = state != IDLE;
    // skew pipeline: column j sees the injection j cycles after column 0
    assign wv_next = (acc_wr_en << 1) | SYS_ARR_COLS'(inject);
    assign wa_next = (acc_wr_addr << AW) | WA'(inject ? cur_addr : '0);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            tile <= '0;
            rows <= '0;
            row <= '0;
            cmd_ready <= 1'b0;
            acc_clear <= 1'b0;
            done <= 1'b0;
            out_valid <= 1'b0;
            out_last <= 1'b0;
            acc_wr_en <= '0;
            acc_wr_addr <= '0;
        end else begin
            acc_wr_en <= wv_next;
            acc_wr_addr <= wa_next;
            out_valid <= rd_go;
            out_last <= rd_go && row == rows - 1'b1;
            acc_clear <= 1'b0;
            done <= 1'b0;
            cmd_ready <= 1'b0;
            if (inject || rd_go) row <= row + 1'b1;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tile <= cmd_tile;
                        rows <= cmd_rows;
                        row <= '0;
                        if (cmd_op == 2'b00) begin
                            state <= CLEAR;
                            acc_clear <= 1'b1;
                        end else if (cmd_op == 2'b11 || cmd_rows == '0) begin
                            state <= DONE;
                            done <= 1'b1;
                        end else begin
                            state <= (cmd_op == 2'b01) ? ACCUM : DRAIN;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                CLEAR: begin
                    state <= DONE;
                    done <= 1'b1;
                end
                ACCUM: if (inject && row + 1'b1 == rows) state <= FLUSH;
                FLUSH: begin
                    if (wv_next == '0) begin
                        state <= DONE;
                        done <= 1'b1;
                    end
                end
                // all reads issued; the last out_valid is on the outputs this cycle
                DRAIN: begin
                    if (!more) begin
`ifdef ACCUM_TABLE_CTRL_CLEAR_ON_DRAIN_EN
                        state <= CLEAR;
                        acc_clear <= 1'b1;
`else
                        state <= DONE;
                        done <= 1'b1;
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
